// File: rtl/next_pc_unit.sv
// Next-PC selection unit: picks the next program address from the current
// command, keeps a hardware return-address stack for CALL/RET, and runs a
// three-state RUN/HALTED/FAULT controller. pcNext/enable are combinational.
module next_pc_unit #(
  parameter int                ADDR_W      = 9,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = 9'd0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              pc,
  input  logic [2:0]                     cmd,
  input  logic [ADDR_W-1:0]              target,
  input  logic                           take,
  input  logic                           stall,
  input  logic                           resume,
  output logic [ADDR_W-1:0]              pcNext,
  output logic                           enable,
  output logic                           halted,
  output logic                           fault,
  output logic                           overflow,
  output logic                           underflow,
  output logic [$clog2(STACK_DEPTH):0]   depth
);

  localparam int DW = $clog2(STACK_DEPTH) + 1;
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DW-1:0] FULL_D = DW'(STACK_DEPTH);

  localparam logic [2:0] CMD_SEQ    = 3'd0;
  localparam logic [2:0] CMD_JUMP   = 3'd1;
  localparam logic [2:0] CMD_BRANCH = 3'd2;
  localparam logic [2:0] CMD_CALL   = 3'd3;
  localparam logic [2:0] CMD_RET    = 3'd4;
  localparam logic [2:0] CMD_HALT   = 3'd5;

  typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_FAULT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   stack [STACK_DEPTH];
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   tos;
  logic [DW-1:0]       depth_m1;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       rd_idx;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                set_ovf;
  logic                set_unf;

  // Address increment wraps modulo 2^ADDR_W with no carry out.
  function automatic logic [ADDR_W-1:0] incr_wrap(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign pc_inc   = incr_wrap(pc);
  assign full     = (depth == FULL_D);
  assign empty    = (depth == '0);
  assign depth_m1 = depth - DW'(1);
  assign wr_idx   = depth[IW-1:0];
  assign rd_idx   = depth_m1[IW-1:0];
  assign tos      = stack[rd_idx];
  assign halted   = (state == ST_HALTED);
  assign fault    = (state == ST_FAULT);

  // Next-address mux, load strobe, stack requests and next FSM state.
  always_comb begin
    pcNext    = pc;
    enable    = 1'b0;
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (rst) begin
      pcNext = RESET_VEC;
      enable = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          // Address selection is independent of stall; stall only gates effects.
          case (cmd)
            CMD_JUMP:   pcNext = target;
            CMD_BRANCH: pcNext = take ? target : pc_inc;
            CMD_CALL:   pcNext = target;
            CMD_RET:    pcNext = empty ? pc : tos;
            CMD_HALT:   pcNext = pc;
            default:    pcNext = pc_inc;
          endcase
          if (!stall) begin
            case (cmd)
              CMD_CALL: begin
                if (full) begin
                  set_ovf   = 1'b1;
                  state_nxt = ST_FAULT;
                end else begin
                  enable = 1'b1;
                  push   = 1'b1;
                end
              end
              CMD_RET: begin
                if (empty) begin
                  set_unf   = 1'b1;
                  state_nxt = ST_FAULT;
                end else begin
                  enable = 1'b1;
                  pop    = 1'b1;
                end
              end
              CMD_HALT: state_nxt = ST_HALTED;
              default:  enable = 1'b1;
            endcase
          end
        end
        ST_HALTED: begin
          if (resume && !stall) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_FAULT;
      endcase
    end
  end

  // Controller state, stack occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push)     depth <= depth + DW'(1);
      else if (pop) depth <= depth_m1;
      if (set_ovf)  overflow  <= 1'b1;
      if (set_unf)  underflow <= 1'b1;
    end
  end

  // Return-address storage; contents survive reset, only depth is cleared.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: a vector table for single-cycle address
// selection plus hand-written sequences for stack, fault, stall and halt cases.
module tb_next_pc_unit;

  logic       clk;
  logic       rst;
  logic [8:0] pc;
  logic [2:0] cmd;
  logic [8:0] target;
  logic       take;
  logic       stall;
  logic       resume;
  logic [8:0] pcNext;
  logic       enable;
  logic       halted;
  logic       fault;
  logic       overflow;
  logic       underflow;
  logic [3:0] depth;

  int n_chk;
  int n_fail;

  next_pc_unit #(.ADDR_W(9), .STACK_DEPTH(8), .RESET_VEC(9'd0)) dut (
    .clk(clk), .rst(rst), .pc(pc), .cmd(cmd), .target(target), .take(take),
    .stall(stall), .resume(resume), .pcNext(pcNext), .enable(enable),
    .halted(halted), .fault(fault), .overflow(overflow), .underflow(underflow),
    .depth(depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd;
    logic [8:0] pc;
    logic [8:0] target;
    logic       take;
    logic [8:0] exp_pc;
    logic       exp_en;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [8:0] p, input logic [8:0] t);
    cmd = c; pc = p; target = t;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; resume = 1'b0; take = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [8:0] pc_model;

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; pc = 9'd77; cmd = 3'd5; target = 9'd0; take = 1'b0;
    stall = 1'b1; resume = 1'b1;

    // Reset outputs override stall/cmd.
    #1;
    chk("rst_pcnext", pcNext, 0);
    chk("rst_enable", enable, 1);
    tick();
    rst = 1'b0; stall = 1'b0; resume = 1'b0;
    #1;
    chk("rst_depth", depth, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // Vector table: RUN state, starting empty stack.
    vecs[0] = '{3'd0, 9'd5,   9'd0,   1'b0, 9'd6,   1'b1};
    vecs[1] = '{3'd0, 9'd511, 9'd0,   1'b0, 9'd0,   1'b1};
    vecs[2] = '{3'd1, 9'd5,   9'd200, 1'b0, 9'd200, 1'b1};
    vecs[3] = '{3'd2, 9'd5,   9'd300, 1'b1, 9'd300, 1'b1};
    vecs[4] = '{3'd2, 9'd5,   9'd300, 1'b0, 9'd6,   1'b1};
    vecs[5] = '{3'd6, 9'd9,   9'd100, 1'b1, 9'd10,  1'b1};
    vecs[6] = '{3'd7, 9'd9,   9'd100, 1'b0, 9'd10,  1'b1};
    vecs[7] = '{3'd3, 9'd5,   9'd100, 1'b0, 9'd100, 1'b1};
    vecs[8] = '{3'd4, 9'd100, 9'd0,   1'b0, 9'd6,   1'b1};
    vecs[9] = '{3'd2, 9'd0,   9'd0,   1'b1, 9'd0,   1'b1};
    for (int i = 0; i < 10; i++) begin
      take = vecs[i].take;
      drive(vecs[i].cmd, vecs[i].pc, vecs[i].target);
      chk($sformatf("vec%0d_pcnext", i), pcNext, vecs[i].exp_pc);
      chk($sformatf("vec%0d_enable", i), enable, vecs[i].exp_en);
      tick();
    end
    chk("vec_depth_end", depth, 0);

    // Sequential wrap with PC fed back.
    do_reset();
    pc_model = 9'd510;
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, pc_model, 9'd0);
      chk($sformatf("wrap%0d_pcnext", i), pcNext, (511 + i) % 512);
      chk($sformatf("wrap%0d_enable", i), enable, 1);
      pc_model = pcNext;
      tick();
    end

    // Call/return and LIFO order.
    do_reset();
    drive(3'd3, 9'd5, 9'd100);
    chk("call_pcnext", pcNext, 100);
    tick();
    chk("call_depth", depth, 1);
    drive(3'd4, 9'd100, 9'd0);
    chk("ret_pcnext", pcNext, 6);
    tick();
    chk("ret_depth", depth, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(3'd3, 9'(i * 10), 9'd400);
      tick();
    end
    for (int i = 3; i >= 1; i--) begin
      drive(3'd4, 9'd400, 9'd0);
      chk($sformatf("lifo%0d_pcnext", i), pcNext, i * 10 + 1);
      tick();
    end
    chk("lifo_depth", depth, 0);

    // Overflow on the ninth CALL, then reset recovery.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(3'd3, 9'(i), 9'(i + 50));
      tick();
    end
    chk("ovf_depth_full", depth, 8);
    drive(3'd3, 9'd57, 9'd200);
    chk("ovf_enable", enable, 0);
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_fault", fault, 1);
    chk("ovf_depth_hold", depth, 8);
    drive(3'd0, 9'd57, 9'd0);
    chk("ovf_frozen_en", enable, 0);
    chk("ovf_frozen_pc", pcNext, 57);
    resume = 1'b1;
    tick();
    chk("ovf_resume_fault", fault, 1);
    resume = 1'b0;
    do_reset();
    chk("ovf_rst_depth", depth, 0);
    chk("ovf_rst_fault", fault, 0);
    chk("ovf_rst_flag", overflow, 0);

    // Underflow on RET with empty stack; resume cannot leave FAULT.
    drive(3'd4, 9'd40, 9'd0);
    chk("unf_enable", enable, 0);
    chk("unf_pcnext", pcNext, 40);
    tick();
    chk("unf_flag", underflow, 1);
    chk("unf_fault", fault, 1);
    resume = 1'b1;
    tick();
    chk("unf_resume_fault", fault, 1);
    resume = 1'b0;

    // Stall priority over CALL and over a would-be faulting RET.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd3, 9'd7, 9'd50);
      chk($sformatf("stall%0d_enable", i), enable, 0);
      tick();
      chk($sformatf("stall%0d_depth", i), depth, 0);
    end
    stall = 1'b0;
    #1;
    chk("stall_release_pc", pcNext, 50);
    chk("stall_release_en", enable, 1);
    tick();
    chk("stall_release_depth", depth, 1);
    stall = 1'b1;
    drive(3'd4, 9'd50, 9'd0);
    tick();
    drive(3'd4, 9'd50, 9'd0);
    tick();
    chk("stall_ret_fault", fault, 0);
    chk("stall_ret_depth", depth, 1);
    stall = 1'b0;

    // Halt/resume with stack preserved across HALTED.
    do_reset();
    drive(3'd3, 9'd3, 9'd20);
    tick();
    drive(3'd5, 9'd20, 9'd0);
    chk("halt_enable", enable, 0);
    chk("halt_pcnext", pcNext, 20);
    tick();
    chk("halt_halted", halted, 1);
    drive(3'd1, 9'd20, 9'd30);
    chk("halted_jump_en", enable, 0);
    chk("halted_jump_pc", pcNext, 20);
    tick();
    chk("halted_still", halted, 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halted", halted, 0);
    drive(3'd1, 9'd20, 9'd30);
    chk("resume_jump_pc", pcNext, 30);
    chk("resume_jump_en", enable, 1);
    tick();
    drive(3'd4, 9'd30, 9'd0);
    chk("halt_stack_kept", pcNext, 4);
    tick();
    chk("halt_stack_depth", depth, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
